// File: rtl/phase_sequencer.sv
// Intersection phase sequencer: ALLRED -> GREEN -> YELLOW -> ALLRED with min/max green
// enforcement, request latching and per-lane lamp drive. All outputs are registered.
module phase_sequencer #(
  parameter int unsigned GREEN_MIN = 8,
  parameter int unsigned GREEN_MAX = 32,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALLRED_T  = 2,
  parameter int unsigned CW        = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] lane_req,
  input  logic       req_valid,
  output logic [3:0] green,
  output logic [3:0] yellow,
  output logic [3:0] red,
  output logic [1:0] phase,
  output logic [3:0] active_lane,
  output logic       switch_pulse,
  output logic       bad_req
);

  typedef enum logic [1:0] {
    StAllred = 2'b00,
    StGreen  = 2'b01,
    StYellow = 2'b10
  } phase_e;

  localparam logic [CW-1:0] AllredLast   = CW'(ALLRED_T - 1);
  localparam logic [CW-1:0] GreenMinLast = CW'(GREEN_MIN - 1);
  localparam logic [CW-1:0] GreenMaxLast = CW'(GREEN_MAX - 1);
  localparam logic [CW-1:0] YellowLast   = CW'(YELLOW_T - 1);

  phase_e        phase_q, phase_d;
  logic [CW-1:0] timer_q, timer_d;
  logic [3:0]    active_q, active_d;
  logic [3:0]    pending_q, pending_d;
  logic [3:0]    target_q, target_d;
  logic [3:0]    green_d, yellow_d;
  logic          req_onehot;

  assign req_onehot = (lane_req != 4'd0) && ((lane_req & (lane_req - 4'd1)) == 4'd0);

  always_comb begin
    phase_d   = phase_q;
    timer_d   = timer_q + 1'b1;
    active_d  = active_q;
    target_d  = target_q;
    pending_d = (req_valid && req_onehot) ? lane_req : pending_q;

    // Exit decisions use pending_q, i.e. the value from before this edge.
    case (phase_q)
      StAllred: begin
        if (timer_q == AllredLast) begin
          phase_d  = StGreen;
          timer_d  = '0;
          active_d = target_q;
        end
      end
      StGreen: begin
        if (timer_q >= GreenMinLast && pending_q != active_q) begin
          phase_d  = StYellow;
          timer_d  = '0;
          target_d = pending_q;
        end else if (timer_q == GreenMaxLast) begin
          phase_d  = StYellow;
          timer_d  = '0;
          target_d = {active_q[2:0], active_q[3]};
        end
      end
      StYellow: begin
        if (timer_q == YellowLast) begin
          phase_d = StAllred;
          timer_d = '0;
        end
      end
      default: begin
        phase_d = StAllred;
        timer_d = '0;
      end
    endcase

    green_d  = (phase_d == StGreen)  ? active_d : 4'd0;
    yellow_d = (phase_d == StYellow) ? active_d : 4'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q      <= StAllred;
      timer_q      <= '0;
      active_q     <= 4'b0001;
      pending_q    <= 4'b0001;
      target_q     <= 4'b0001;
      green        <= 4'b0000;
      yellow       <= 4'b0000;
      red          <= 4'b1111;
      switch_pulse <= 1'b0;
      bad_req      <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      timer_q      <= timer_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      target_q     <= target_d;
      green        <= green_d;
      yellow       <= yellow_d;
      red          <= ~(green_d | yellow_d);
      switch_pulse <= (phase_d == StGreen) && (phase_q != StGreen);
      bad_req      <= req_valid && !req_onehot;
    end
  end

  assign phase       = phase_q;
  assign active_lane = active_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: directed scenarios with literal expectations, then randomized
// requests/resets, all outputs compared every cycle against a cycle-count reference model.
module tb_phase_sequencer;

  localparam int GMIN = 8;
  localparam int GMAX = 32;
  localparam int YT   = 3;
  localparam int ART  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] lane_req;
  logic       req_valid;
  logic [3:0] green, yellow, red, active_lane;
  logic [1:0] phase;
  logic       switch_pulse, bad_req;

  int checks   = 0;
  int failures = 0;
  bit checking = 1'b0;

  phase_sequencer #(
    .GREEN_MIN(GMIN),
    .GREEN_MAX(GMAX),
    .YELLOW_T (YT),
    .ALLRED_T (ART),
    .CW       (6)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .lane_req    (lane_req),
    .req_valid   (req_valid),
    .green       (green),
    .yellow      (yellow),
    .red         (red),
    .phase       (phase),
    .active_lane (active_lane),
    .switch_pulse(switch_pulse),
    .bad_req     (bad_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase as 0/1/2, elapsed = cycles already completed in this phase.
  int m_phase, m_elapsed, m_active, m_pending, m_target, m_bad, m_pulse;

  initial forever begin
    int old_pend;
    bit onehot;
    @(posedge clk);
    if (rst) begin
      m_phase = 0; m_elapsed = 0; m_active = 1; m_pending = 1; m_target = 1;
      m_bad = 0; m_pulse = 0;
    end else begin
      onehot   = ($countones(lane_req) == 1);
      m_bad    = (req_valid && !onehot) ? 1 : 0;
      m_pulse  = 0;
      old_pend = m_pending;
      if (req_valid && onehot) m_pending = int'(lane_req);
      m_elapsed++;
      if (m_phase == 0) begin
        if (m_elapsed == ART) begin
          m_phase = 1; m_elapsed = 0; m_active = m_target; m_pulse = 1;
        end
      end else if (m_phase == 1) begin
        if (m_elapsed >= GMIN && old_pend != m_active) begin
          m_phase = 2; m_elapsed = 0; m_target = old_pend;
        end else if (m_elapsed == GMAX) begin
          m_phase = 2; m_elapsed = 0;
          m_target = (m_active == 8) ? 1 : m_active * 2;
        end
      end else begin
        if (m_elapsed == YT) begin
          m_phase = 0; m_elapsed = 0;
        end
      end
    end
  end

  initial forever begin
    int eg, ey;
    @(negedge clk);
    if (checking) begin
      eg = (m_phase == 1) ? m_active : 0;
      ey = (m_phase == 2) ? m_active : 0;
      chk("green",        32'(green),        32'(eg));
      chk("yellow",       32'(yellow),       32'(ey));
      chk("red",          32'(red),          32'((~(eg | ey)) & 15));
      chk("phase",        32'(phase),        32'(m_phase));
      chk("active_lane",  32'(active_lane),  32'(m_active));
      chk("switch_pulse", 32'(switch_pulse), 32'(m_pulse));
      chk("bad_req",      32'(bad_req),      32'(m_bad));
    end
  end

  // Called on a negedge inside phase p; returns on the first negedge outside it.
  task automatic count_phase(input logic [1:0] p, output int n);
    n = 0;
    while (phase == p && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic req_pulse(input logic [3:0] lane);
    req_valid = 1'b1;
    lane_req  = lane;
    @(negedge clk);
    req_valid = 1'b0;
    lane_req  = 4'd0;
  endtask

  initial begin
    int n;
    rst = 1'b1; req_valid = 1'b0; lane_req = 4'd0;
    @(posedge clk);
    checking = 1'b1;

    // Reset and first green
    @(negedge clk);
    @(negedge clk);
    chk("reset_red", 32'(red), 32'hf);
    chk("reset_phase", 32'(phase), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("allred_after_release", 32'(phase), 32'h0);
    @(negedge clk);
    chk("first_green", 32'(green), 32'h1);
    chk("first_pulse", 32'(switch_pulse), 32'h1);

    // No requests: full max green then rotation N->E
    count_phase(2'b01, n);
    chk("n_green_len_max", 32'(n), 32'(GMAX));
    chk("n_yellow", 32'(yellow), 32'h1);
    count_phase(2'b10, n);
    chk("yellow_len", 32'(n), 32'(YT));
    count_phase(2'b00, n);
    chk("allred_len", 32'(n), 32'(ART));
    chk("rotate_to_e", 32'(green), 32'h2);

    // Request S at timer 2: min green, then S
    @(negedge clk);
    @(negedge clk);
    req_pulse(4'b0100);
    count_phase(2'b01, n);
    chk("e_green_len_min", 32'(n + 3), 32'(GMIN));
    count_phase(2'b10, n);
    count_phase(2'b00, n);
    chk("serve_s", 32'(green), 32'h4);

    // Request E at timer 12: exit decided on the following edge
    repeat (12) @(negedge clk);
    req_pulse(4'b0010);
    chk("still_green_t13", 32'(phase), 32'h1);
    @(negedge clk);
    chk("yellow_after_late_req", 32'(yellow), 32'h4);
    count_phase(2'b10, n);
    count_phase(2'b00, n);
    chk("serve_e", 32'(green), 32'h2);

    // Malformed requests are flagged and ignored
    req_valid = 1'b1; lane_req = 4'b0110;
    @(negedge clk);
    chk("bad_multi", 32'(bad_req), 32'h1);
    lane_req = 4'b0000;
    @(negedge clk);
    chk("bad_zero", 32'(bad_req), 32'h1);
    req_valid = 1'b0;
    @(negedge clk);
    chk("bad_clear", 32'(bad_req), 32'h0);
    count_phase(2'b01, n);
    chk("e_green_len_after_bad", 32'(n + 3), 32'(GMAX));
    count_phase(2'b10, n);
    count_phase(2'b00, n);
    chk("rotate_to_s", 32'(green), 32'h4);

    // Move to W, let it time out, wrap to N, then reset during yellow
    req_pulse(4'b1000);
    count_phase(2'b01, n);
    count_phase(2'b10, n);
    count_phase(2'b00, n);
    chk("serve_w", 32'(green), 32'h8);
    count_phase(2'b01, n);
    chk("w_green_len_max", 32'(n), 32'(GMAX));
    count_phase(2'b10, n);
    count_phase(2'b00, n);
    chk("wrap_to_n", 32'(green), 32'h1);
    count_phase(2'b01, n);
    chk("n_green_len_pending_w", 32'(n), 32'(GMIN));
    chk("in_yellow", 32'(phase), 32'h2);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_yellow_phase", 32'(phase), 32'h0);
    chk("rst_mid_yellow_red", 32'(red), 32'hf);
    chk("rst_mid_yellow_active", 32'(active_lane), 32'h1);
    rst = 1'b0;

    // Randomized traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      req_valid = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 4) == 0) lane_req = 4'($urandom_range(0, 15));
      else lane_req = 4'(1 << $urandom_range(0, 3));
      @(negedge clk);
    end
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
